// File: rtl/core_pkg.sv
// Shared definitions for the main core and its instruction feeder:
// HALT opcode, opcode field position and the feeder state encoding.
package core_pkg;

  localparam logic [5:0] OPC_HALT = 6'b010001;
  localparam int         OPC_MSB  = 31;
  localparam int         OPC_LSB  = 26;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_HALT    = 2'd3
  } feeder_state_t;

  function automatic logic is_halt(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB] == OPC_HALT;
  endfunction

endpackage

// File: rtl/inst_mem.sv
// Instruction image: one write port, one synchronous read port (1-cycle latency).
// The read register only updates when re is high, so the last word read is held.
module inst_mem #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Array contents are deliberately not reset so a loaded image survives reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/inst_feeder.sv
// Presents one instruction at a time to the core over valid/opr_finished and stops on HALT.
// Optional watchdog in PRESENT is built only when INST_FEEDER_WATCHDOG_EN is defined.
module inst_feeder
  import core_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              start,
  input  logic              opr_finished,
  output logic              valid,
  output logic [31:0]       inst_word,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic [31:0]       inst_count,
  output logic              timeout_err
);

  feeder_state_t     state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       count_q, count_d;
  logic              halted_q, halted_d;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_rdata;

`ifdef INST_FEEDER_WATCHDOG_EN
  localparam int             WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q, timeout_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  // The image is only writable while nothing is being read from it.
  assign mem_we = load_en && ((state_q == ST_IDLE) || (state_q == ST_HALT));

  inst_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_inst_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (mem_re),
    .raddr (pc_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    halted_d = halted_q;
    mem_re   = 1'b0;
`ifdef INST_FEEDER_WATCHDOG_EN
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d  = ST_FETCH;
          pc_d     = '0;
          count_d  = '0;
          halted_d = 1'b0;
`ifdef INST_FEEDER_WATCHDOG_EN
          timeout_d = 1'b0;
`endif
        end
      end
      ST_FETCH: begin
        mem_re  = 1'b1;
        state_d = ST_PRESENT;
`ifdef INST_FEEDER_WATCHDOG_EN
        wd_cnt_d = '0;
`endif
      end
      ST_PRESENT: begin
        if (opr_finished) begin
          if (count_q != 32'hFFFF_FFFF) begin
            count_d = count_q + 32'd1;
          end
          if (is_halt(mem_rdata)) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            state_d = ST_FETCH;
            pc_d    = pc_q + ADDR_W'(1);
          end
        end
`ifdef INST_FEEDER_WATCHDOG_EN
        else if (wd_cnt_q == WD_LAST) begin
          state_d   = ST_HALT;
          timeout_d = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

`ifdef INST_FEEDER_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign valid      = (state_q == ST_PRESENT);
  assign inst_word  = mem_rdata;
  assign pc_out     = pc_q;
  assign halted     = halted_q;
  assign inst_count = count_q;

endmodule

// File: tb/tb_inst_feeder.sv
// Self-checking bench for inst_feeder: a cycle table for the straight-line run plus
// hand-written sequences for back-pressure, ignored events, reset, wrap and watchdog.
module tb_inst_feeder;

  localparam int DEPTH       = 4;
  localparam int ADDR_W      = 2;
  localparam int TIMEOUT_CYC = 16;
`ifdef INST_FEEDER_WATCHDOG_EN
  localparam int BP_CYC = 12;
`else
  localparam int BP_CYC = 20;
`endif

  logic              clk;
  logic              reset;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              start;
  logic              opr_finished;
  logic              valid;
  logic [31:0]       inst_word;
  logic [ADDR_W-1:0] pc_out;
  logic              halted;
  logic [31:0]       inst_count;
  logic              timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  inst_feeder #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .start        (start),
    .opr_finished (opr_finished),
    .valid        (valid),
    .inst_word    (inst_word),
    .pc_out       (pc_out),
    .halted       (halted),
    .inst_count   (inst_count),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        start;
    logic        opr;
    logic        exp_valid;
    logic [31:0] exp_word;
    logic [1:0]  exp_pc;
    logic [31:0] exp_cnt;
    logic        exp_halted;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [1:0] addr, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    tick();
    load_en = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!valid && n < budget) begin
      tick();
      n++;
    end
    check("wait_valid", {31'd0, valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    //           start opr  valid word           pc    cnt    halted
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 2'd0, 32'd0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h2001_0005, 2'd0, 32'd0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h2001_0005, 2'd1, 32'd1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h2002_0003, 2'd1, 32'd1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h2002_0003, 2'd2, 32'd2, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h4400_0000, 2'd2, 32'd2, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h4400_0000, 2'd2, 32'd3, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 32'h4400_0000, 2'd2, 32'd3, 1'b1};

    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; opr_finished = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Straight-line run
    load_word(2'd0, 32'h2001_0005);
    load_word(2'd1, 32'h2002_0003);
    load_word(2'd2, 32'h4400_0000);
    for (int i = 0; i < 8; i++) begin
      start        = vecs[i].start;
      opr_finished = vecs[i].opr;
      tick();
      start        = 1'b0;
      opr_finished = 1'b0;
      $display("vec %0d: valid=%0b word=%h pc=%0d cnt=%0d halted=%0b",
               i, valid, inst_word, pc_out, inst_count, halted);
      check($sformatf("vec%0d_valid", i), {31'd0, valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d_word", i), inst_word, vecs[i].exp_word);
      check($sformatf("vec%0d_pc", i), {30'd0, pc_out}, {30'd0, vecs[i].exp_pc});
      check($sformatf("vec%0d_cnt", i), inst_count, vecs[i].exp_cnt);
      check($sformatf("vec%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].exp_halted});
    end

    // Restart from HALT clears pc/count/halted
    start = 1'b1;
    tick();
    start = 1'b0;
    $display("restart from halt: pc=%0d cnt=%0d halted=%0b", pc_out, inst_count, halted);
    check("restart_pc", {30'd0, pc_out}, 32'd0);
    check("restart_cnt", inst_count, 32'd0);
    check("restart_halted", {31'd0, halted}, 32'd0);
    check("restart_fetch_valid", {31'd0, valid}, 32'd0);
    tick();
    check("restart_valid", {31'd0, valid}, 32'd1);
    check("restart_word", inst_word, 32'h2001_0005);

    // Back-pressure with a dropped load and an ignored start in PRESENT
    for (int i = 0; i < BP_CYC; i++) begin
      if (i == 3) begin
        load_en = 1'b1; load_addr = 2'd0; load_data = 32'hDEAD_BEEF;
      end
      if (i == 6) start = 1'b1;
      tick();
      load_en = 1'b0;
      start   = 1'b0;
      check("bp_valid", {31'd0, valid}, 32'd1);
      check("bp_word", inst_word, 32'h2001_0005);
      check("bp_cnt", inst_count, 32'd0);
      check("bp_pc", {30'd0, pc_out}, 32'd0);
    end
    $display("back-pressure held %0d cycles: word=%h cnt=%0d", BP_CYC, inst_word, inst_count);
    opr_finished = 1'b1;
    tick();
    check("bp_release_valid", {31'd0, valid}, 32'd0);
    check("bp_release_cnt", inst_count, 32'd1);
    for (int n = 0; n < 10 && !halted; n++) tick();
    opr_finished = 1'b0;
    $display("run to halt: cnt=%0d pc=%0d halted=%0b", inst_count, pc_out, halted);
    check("bp_halted", {31'd0, halted}, 32'd1);
    check("bp_final_cnt", inst_count, 32'd3);
    check("bp_final_pc", {30'd0, pc_out}, 32'd2);

    // Rerun: word 0 must not have taken the dropped write
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(3);
    $display("rerun word0=%h", inst_word);
    check("rerun_word0", inst_word, 32'h2001_0005);

    // Reset from PRESENT, load a wrap image, reset again: image must survive
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) load_word(2'(i), 32'h1000_0000 + 32'(i));
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    $display("after reset: valid=%0b word=%h pc=%0d cnt=%0d halted=%0b to=%0b",
             valid, inst_word, pc_out, inst_count, halted, timeout_err);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_word", inst_word, 32'd0);
    check("rst_pc", {30'd0, pc_out}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_cnt", inst_count, 32'd0);
    check("rst_timeout", {31'd0, timeout_err}, 32'd0);

    opr_finished = 1'b1;
    tick();
    opr_finished = 1'b0;
    tick();
    check("idle_opr_cnt", inst_count, 32'd0);
    check("idle_opr_valid", {31'd0, valid}, 32'd0);

    // Wrap: six completions over a four-word image without HALT
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wait_valid(4);
      $display("wrap %0d: pc=%0d word=%h", k, pc_out, inst_word);
      check("wrap_pc", {30'd0, pc_out}, 32'(k % 4));
      check("wrap_word", inst_word, 32'h1000_0000 + 32'(k % 4));
      opr_finished = 1'b1;
      tick();
      opr_finished = 1'b0;
      check("wrap_cnt", inst_count, 32'(k + 1));
    end
    check("wrap_final_pc", {30'd0, pc_out}, 32'd2);
    check("wrap_no_halt", {31'd0, halted}, 32'd0);
    check("wrap_no_timeout", {31'd0, timeout_err}, 32'd0);

`ifdef INST_FEEDER_WATCHDOG_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("wd_valid_rise", {31'd0, valid}, 32'd1);
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) tick();
    check("wd_not_yet", {31'd0, timeout_err}, 32'd0);
    check("wd_still_valid", {31'd0, valid}, 32'd1);
    tick();
    $display("watchdog: to=%0b valid=%0b halted=%0b cnt=%0d", timeout_err, valid, halted, inst_count);
    check("wd_fired", {31'd0, timeout_err}, 32'd1);
    check("wd_valid_low", {31'd0, valid}, 32'd0);
    check("wd_halted_low", {31'd0, halted}, 32'd0);
    check("wd_cnt", inst_count, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("wd_cleared", {31'd0, timeout_err}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
